// File: rtl/seven_seg_scanner_if.sv
// Bundles the display-value and display-drive signals of the seven-segment scanner.
// The master drives value/enables and observes the scanner outputs.
interface seven_seg_scanner_if;
    logic [15:0] value;
    logic        value_load;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, value_load, digit_en, dp_in,
        input  nibble, an, dp, frame_done
    );

    modport slave (
        input  value, value_load, digit_en, dp_in,
        output nibble, an, dp, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display scanner: walks digit slots, blanks the anodes at the
// start of each slot to suppress ghosting, and swaps in new display values only at frame edges.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    seven_seg_scanner_if.slave  bus
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     pending_q, pending_d;
    logic            pending_flag_q, pending_flag_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;
    logic [3:0]      nibble_q, nibble_d;
    logic            frame_done_q, frame_done_d;
    logic            cnt_wrap;
    logic            frame_end;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_wrap       = (cnt_q == CW'(REFRESH_DIV - 1));
        frame_end      = cnt_wrap && (idx_q == 2'd3);
        cnt_d          = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d          = cnt_wrap ? idx_q + 2'd1 : idx_q;

        state_d        = state_q;
        pending_d      = pending_q;
        pending_flag_d = pending_flag_q;
        shadow_d       = shadow_q;
        an_d           = 4'hF;
        dp_d           = 1'b1;
        nibble_d       = nibble_q;
        frame_done_d   = (idx_d == 2'd3) && (cnt_d == CW'(REFRESH_DIV - 1));

        case (state_q)
            ST_BLANK: if (cnt_d == CW'(BLANK_CYCLES)) state_d = ST_SHOW;
            ST_SHOW:  if (cnt_wrap)                   state_d = ST_BLANK;
            default:                                  state_d = ST_BLANK;
        endcase

        if (bus.value_load) begin
            pending_d      = bus.value;
            pending_flag_d = 1'b1;
        end

        // A load landing on the frame edge itself beats whatever was already pending.
        if (frame_end) begin
            if (bus.value_load)      shadow_d = bus.value;
            else if (pending_flag_q) shadow_d = pending_q;
            pending_flag_d = 1'b0;
        end

        if (cnt_d == '0) nibble_d = shadow_d[{idx_d, 2'b00} +: 4];

        if ((state_d == ST_SHOW) && bus.digit_en[idx_d]) begin
            an_d[idx_d] = 1'b0;
            dp_d        = ~bus.dp_in[idx_d];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            idx_q          <= 2'd0;
            pending_q      <= 16'h0;
            pending_flag_q <= 1'b0;
            shadow_q       <= 16'h0;
            an_q           <= 4'hF;
            dp_q           <= 1'b1;
            nibble_q       <= 4'h0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            pending_flag_q <= pending_flag_d;
            shadow_q       <= shadow_d;
            an_q           <= an_d;
            dp_q           <= dp_d;
            nibble_q       <= nibble_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.nibble     = nibble_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a per-slot table of stimulus and expected outputs,
// plus hand-written reset sequences.
module tb_seven_seg_scanner;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scanner_if bus();

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0]  digit_en;
        logic [3:0]  dp_in;
        int          load_at;     // cycle within the slot carrying value_load, -1 for none
        logic [15:0] load_val;
        logic [3:0]  exp_nibble;
        logic [3:0]  exp_an;      // anodes during the SHOW window
        logic        exp_dp;      // dp during the SHOW window
    } slot_vec_t;

    slot_vec_t vecs[22];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] an, input logic dp,
                                 input logic [3:0] nib, input logic fd);
        check({tag, " an"},         {12'h0, bus.an},         {12'h0, an});
        check({tag, " dp"},         {15'h0, bus.dp},         {15'h0, dp});
        check({tag, " nibble"},     {12'h0, bus.nibble},     {12'h0, nib});
        check({tag, " frame_done"}, {15'h0, bus.frame_done}, {15'h0, fd});
    endtask

    // Entered on cycle 0 of a slot; leaves on cycle 0 of the following slot.
    task automatic run_slot(input int s, input slot_vec_t v, input bit last);
        bus.digit_en = v.digit_en;
        bus.dp_in    = v.dp_in;
        for (int c = 0; c < int'(RD); c++) begin
            check_outputs($sformatf("slot%0d cyc%0d", s, c),
                          (c < int'(BC)) ? 4'hF : v.exp_an,
                          (c < int'(BC)) ? 1'b1 : v.exp_dp,
                          v.exp_nibble,
                          last && (c == int'(RD) - 1));
            if (c == v.load_at) begin
                bus.value      = v.load_val;
                bus.value_load = 1'b1;
            end
            tick();
            bus.value_load = 1'b0;
        end
    endtask

    initial begin
        slot_vec_t  v;
        logic [3:0] onehot;

        bus.value      = 16'h0;
        bus.value_load = 1'b0;
        bus.digit_en   = 4'hF;
        bus.dp_in      = 4'h0;

        // Frame 0: shadow still zero; queue 1A3F.
        vecs[0]  = '{4'hF, 4'h0,  3, 16'h1A3F, 4'h0, 4'b1110, 1'b1};
        vecs[1]  = '{4'hF, 4'h0, -1, 16'h0,    4'h0, 4'b1101, 1'b1};
        vecs[2]  = '{4'hF, 4'h0, -1, 16'h0,    4'h0, 4'b1011, 1'b1};
        vecs[3]  = '{4'hF, 4'h0, -1, 16'h0,    4'h0, 4'b0111, 1'b1};
        // Frame 1: shows 1A3F; 1234 loaded mid-frame must not tear slots 2/3.
        vecs[4]  = '{4'hF, 4'h0, -1, 16'h0,    4'hF, 4'b1110, 1'b1};
        vecs[5]  = '{4'hF, 4'h0,  4, 16'h1234, 4'h3, 4'b1101, 1'b1};
        vecs[6]  = '{4'hF, 4'h0, -1, 16'h0,    4'hA, 4'b1011, 1'b1};
        vecs[7]  = '{4'hF, 4'h0, -1, 16'h0,    4'h1, 4'b0111, 1'b1};
        // Frame 2: shows 1234; BEEF pending, then 0C0D loaded on the frame_done cycle.
        vecs[8]  = '{4'hF, 4'h0,  3, 16'hBEEF, 4'h4, 4'b1110, 1'b1};
        vecs[9]  = '{4'hF, 4'h0, -1, 16'h0,    4'h3, 4'b1101, 1'b1};
        vecs[10] = '{4'hF, 4'h0, -1, 16'h0,    4'h2, 4'b1011, 1'b1};
        vecs[11] = '{4'hF, 4'h0,  7, 16'h0C0D, 4'h1, 4'b0111, 1'b1};
        // Frame 3: shows 0C0D with digits 1 and 3 masked; dp request on masked digit 3.
        vecs[12] = '{4'b0101, 4'b1000, -1, 16'h0, 4'hD, 4'b1110, 1'b1};
        vecs[13] = '{4'b0101, 4'b1000, -1, 16'h0, 4'h0, 4'b1111, 1'b1};
        vecs[14] = '{4'b0101, 4'b1000, -1, 16'h0, 4'hC, 4'b1011, 1'b1};
        vecs[15] = '{4'b0101, 4'b1000, -1, 16'h0, 4'h0, 4'b1111, 1'b1};
        // Frame 4: still 0C0D (BEEF must not resurface); all enabled, dp lit on digit 3.
        vecs[16] = '{4'hF, 4'b1000, -1, 16'h0, 4'hD, 4'b1110, 1'b1};
        vecs[17] = '{4'hF, 4'b1000, -1, 16'h0, 4'h0, 4'b1101, 1'b1};
        vecs[18] = '{4'hF, 4'b1000, -1, 16'h0, 4'hC, 4'b1011, 1'b1};
        vecs[19] = '{4'hF, 4'b1000, -1, 16'h0, 4'h0, 4'b0111, 1'b0};
        // Frame 5, first two slots, before the mid-operation reset.
        vecs[20] = '{4'hF, 4'h0, -1, 16'h0, 4'hD, 4'b1110, 1'b1};
        vecs[21] = '{4'hF, 4'h0, -1, 16'h0, 4'h0, 4'b1101, 1'b1};

        for (int i = 0; i < 3; i++) begin
            tick();
            check_outputs($sformatf("in_reset%0d", i), 4'hF, 1'b1, 4'h0, 1'b0);
        end
        reset = 1'b0;

        for (int s = 0; s < 22; s++) run_slot(s, vecs[s], (s % 4) == 3);

        // Frame 5, slot 2: advance into SHOW, then hit reset between clock edges.
        for (int c = 0; c < 4; c++) tick();
        check_outputs("pre_reset", 4'b1011, 1'b1, 4'hC, 1'b0);
        #2 reset = 1'b1;
        #1 check_outputs("async_reset", 4'hF, 1'b1, 4'h0, 1'b0);
        tick();
        tick();
        check_outputs("held_reset", 4'hF, 1'b1, 4'h0, 1'b0);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) begin
            onehot = 4'b0001 << k;
            v = '{4'hF, 4'h0, -1, 16'h0, 4'h0, ~onehot, 1'b1};
            run_slot(100 + k, v, k == 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
